demux_lane_packer: RTL and testbench
====================================

# demux_lane_packer

Collects the single-bit traffic leaving the 1-to-4 bit demultiplexer (`demuxer4`) and packs it into WIDTH-bit words per channel. Each of the four lanes has its own shift register and holding register. Completed words are forwarded one at a time over a valid/ready output port, chosen by round-robin arbitration. The block sits directly downstream of the demultiplexer: it takes the demultiplexer's `out[3:0]` plus the same `sel` and a bit strobe.

## Interface
Parameters:
- WIDTH, 8: bits per packed word; legal range 2..32.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- bit_valid  in  1  a demultiplexed bit is present this cycle.
- sel  in  2  channel select that drove the demultiplexer this cycle.
- lanes  in  4  demultiplexer outputs; only `lanes[sel]` is sampled.
- out_valid  out  1  out_data/out_chan hold a word.
- out_ready  in  1  consumer accepts the word this cycle.
- out_data  out  WIDTH  packed word; first-received bit in bit 0.
- out_chan  out  2  channel the word came from.
- overflow  out  4  sticky per-channel flag: a completed word was dropped.

## Operation
- Sampling:
  - On `bit_valid=1`, bit b = `lanes[sel]`; the other lanes are ignored.
  - Channel `sel` shifts LSB-first: `shreg <= {b, shreg[WIDTH-1:1]}`; `cnt <= cnt+1`.
  - When `cnt` reaches WIDTH-1 together with an incoming bit, the word is complete.
- Word completion on channel c:
  - The assembled word (including the current bit) is written to `hold_c`, and `hold_valid_c` is set.
  - `cnt` returns to 0.
  - If `hold_valid_c` is already 1 and is not being drained in the same cycle, the new word is dropped and `overflow[c]` is set.
  - If the hold register is drained in the same cycle the new word completes, the new word is accepted and no overflow is flagged.
- Output register:
  - Loads when `out_valid=0` or `out_ready=1`, and at least one `hold_valid` is set.
  - The granted channel's `hold_valid` clears in the same cycle as the load.
  - With no pending word and `out_ready=1`, `out_valid` drops to 0.
- Arbitration: round-robin. The search starts at (last granted + 1) mod 4; the pointer starts at channel 0 after reset.
- Out-of-band lane activity: `bit_valid=0` means lanes are don't-care and no state changes.
- `overflow` bits clear only on reset.
- Reset (any cycle, including mid-word):
  - Clears all shift registers, counters, `hold_valid`, the round-robin pointer and `overflow`.
  - Partial words are discarded.
  - Outputs after reset: out_valid=0, out_data=0, out_chan=0, overflow=0000.

## Timing
- Latency: the last bit of a word is sampled at edge t. `hold_valid` is set after t. With the output free, `out_valid=1` after edge t+1: two cycles from last-bit strobe to out_valid.
- Throughput: one word per cycle on the output while `out_ready=1` and words are pending.
- Handshake:
  - While `out_valid=1` and `out_ready=0`, out_data/out_chan are stable.
  - A transfer occurs on an edge where both out_valid and out_ready are 1.
- Buffering per channel: one word in `hold_c`, plus at most one more for the same channel in the output register. Overflow occurs only on a third completion while both are occupied.

## Structure
- Package `demux_pkg`:
  - `LANES=4`
  - `typedef logic [1:0] chan_t`
  - round-robin next-pointer function
- Sub-module `demux_lane_shifter` (parameter WIDTH), instantiated four times:
  - shift register, counter, hold register, hold_valid, overflow flag
  - ports: clk, rst, shift_en, bit_in, drain, hold_valid, hold_data, overflow
- Top level holds the output register and the arbiter.

## Test plan
- Reset: assert rst for 2 cycles with random lanes and bit_valid=1. Required: out_valid=0, out_data=0, out_chan=0, overflow=0000, and nothing emitted afterwards until a full word is sent.
- Single word, WIDTH=8: send bits 1,0,1,1,0,0,1,0 on sel=0 with out_ready=1. Required: out_data=8'h4D, out_chan=0, out_valid high two cycles after the 8th strobe, for one cycle.
- Interleaved: alternate sel=1 (all 1s) and sel=2 (bits of 8'hA5, LSB first). Required: ch1 emits 8'hFF, then ch2 emits 8'hA5, in completion order.
- Arbitration: complete one word on each of ch0..3 with out_ready=0, then raise out_ready. Required: out_chan order 0,1,2,3 on consecutive cycles. A following ch0/ch3 pair completing together is granted ch0 first (pointer after 3 wraps to 0).
- Overflow: three words on ch3 (8'h11, 8'h22, 8'h33) with out_ready=0. Required: overflow=4'b1000, out_data=8'h11 held stable. After out_ready=1, only 8'h11 and 8'h22 are emitted.
- Reset mid-word: 5 bits on ch2, then rst for 1 cycle, then 8 bits of 8'h3C. Required: exactly one word, 8'h3C on ch2, with no residue from the first 5 bits.

Source files
------------

// File: rtl/demux_pkg.sv
// demux_pkg: shared lane count, channel type and round-robin helpers for the lane packer.
package demux_pkg;
  localparam int LANES = 4;
  typedef logic [1:0] chan_t;
  function automatic chan_t rr_next(chan_t g);
    return g + 2'd1;
  endfunction
  function automatic chan_t rr_pick(chan_t start, logic [LANES-1:0] req);
    chan_t c;
    rr_pick = start;
    for (int k = LANES - 1; k >= 0; k--) begin
      c = start + chan_t'(k);
      if (req[c]) rr_pick = c;
    end
  endfunction
endpackage

// File: rtl/demux_lane_shifter.sv
// demux_lane_shifter: LSB-first word assembly for one lane with a single-entry hold register.
module demux_lane_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic             drain,
  output logic             hold_valid,
  output logic [WIDTH-1:0] hold_data,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-2:0] sh;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] word;
  logic done;
  assign word = {bit_in, sh};
  assign done = shift_en && cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      sh <= '0;
      cnt <= '0;
      hold_valid <= 1'b0;
      hold_data <= '0;
      overflow <= 1'b0;
    end else begin
      if (shift_en) begin
        sh <= word[WIDTH-1:1];
        cnt <= done ? '0 : cnt + 1'b1;
      end
      // a drain in the completion cycle frees the slot for the new word
      if (done && hold_valid && !drain) overflow <= 1'b1;
      else if (done) begin
        hold_data <= word;
        hold_valid <= 1'b1;
      end else if (drain) hold_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/demux_lane_packer.sv
// demux_lane_packer: packs demuxed bits into per-lane words and forwards them round-robin over valid/ready.
module demux_lane_packer
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_valid,
  input  logic [1:0]       sel,
  input  logic [3:0]       lanes,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_chan,
  output logic [3:0]       overflow
);
  logic [LANES-1:0] hv, drain;
  logic [WIDTH-1:0] hd [LANES];
  chan_t ptr, g;
  logic load;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    demux_lane_shifter #(.WIDTH(WIDTH)) u_lane (
      .clk(clk),
      .rst(rst),
      .shift_en(bit_valid && sel == chan_t'(i)),
      .bit_in(lanes[sel]),
      .drain(drain[i]),
      .hold_valid(hv[i]),
      .hold_data(hd[i]),
      .overflow(overflow[i])
    );
  end
  always_comb begin
    g = rr_pick(ptr, hv);
    load = (!out_valid || out_ready) && |hv;
    drain = load ? 4'b0001 << g : 4'b0000;
  end
  // ptr holds the channel where the next search begins
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_chan <= '0;
      ptr <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data <= hd[g];
      out_chan <= g;
      ptr <= rr_next(g);
    end else if (out_ready) out_valid <= 1'b0;
  end
endmodule

// File: tb/tb_demux_lane_packer.sv
// tb_demux_lane_packer: directed table, corner sequences and randomized traffic against a queue-level reference model.
module tb_demux_lane_packer;
  localparam int W = 8;
  logic clk = 0, rst = 1, bit_valid = 0, out_ready = 0;
  logic [1:0] sel = 0;
  logic [3:0] lanes = 0;
  logic out_valid;
  logic [W-1:0] out_data;
  logic [1:0] out_chan;
  logic [3:0] overflow;
  int checks = 0, errors = 0;
  logic [9:0] emit[$];
  int m_acc[4], m_n[4], m_ptr, m_c;
  bit m_hv[4], m_ov[4], m_v;
  logic [7:0] m_hw[4], m_d;
  typedef struct {logic [1:0] ch; logic [7:0] seq; logic [7:0] exp;} vec_t;
  vec_t tbl[4];

  demux_lane_packer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .sel(sel), .lanes(lanes),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_chan(out_chan), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic void model_step(bit r, bit bv, int s, bit b, bit rdy);
    int g;
    if (r) begin
      for (int c = 0; c < 4; c++) begin
        m_acc[c] = 0; m_n[c] = 0; m_hv[c] = 0; m_ov[c] = 0; m_hw[c] = 0;
      end
      m_v = 0; m_d = 0; m_c = 0; m_ptr = 0;
      return;
    end
    g = -1;
    if (!m_v || rdy)
      for (int k = 0; k < 4; k++)
        if (g < 0 && m_hv[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
    if (g >= 0) begin
      m_v = 1; m_d = m_hw[g]; m_c = g; m_ptr = (g + 1) % 4; m_hv[g] = 0;
    end else if (rdy) m_v = 0;
    if (bv) begin
      m_acc[s] += int'(b) << m_n[s];
      m_n[s]++;
      if (m_n[s] == W) begin
        if (m_hv[s]) m_ov[s] = 1;
        else begin m_hw[s] = 8'(m_acc[s]); m_hv[s] = 1; end
        m_acc[s] = 0; m_n[s] = 0;
      end
    end
  endfunction

  task automatic cyc(input logic r, input logic bv, input logic [1:0] s, input logic [3:0] ln, input logic rdy);
    logic [3:0] mov;
    rst = r; bit_valid = bv; sel = s; lanes = ln; out_ready = rdy;
    if (!r && out_valid && out_ready) emit.push_back({out_chan, out_data});
    model_step(r, bv, s, ln[s], rdy);
    @(posedge clk);
    #1;
    mov = {m_ov[3], m_ov[2], m_ov[1], m_ov[0]};
    chk("out_valid", 32'(out_valid), 32'(m_v));
    chk("overflow", 32'(overflow), 32'(mov));
    if (m_v) begin
      chk("out_data", 32'(out_data), 32'(m_d));
      chk("out_chan", 32'(out_chan), 32'(m_c));
    end
  endtask

  function automatic logic [3:0] lanes_with(logic [1:0] ch, logic b);
    logic [3:0] l = 4'($urandom);
    l[ch] = b;
    return l;
  endfunction

  task automatic send_word(input logic [1:0] ch, input logic [7:0] w, input logic rdy);
    for (int i = 0; i < 8; i++) cyc(0, 1, ch, lanes_with(ch, w[i]), rdy);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(0, 0, 2'($urandom), 4'($urandom), rdy);
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0, 1);
    emit.delete();
  endtask

  initial begin
    tbl[0] = '{2'd0, 8'b10110010, 8'h4D};
    tbl[1] = '{2'd1, 8'b11110000, 8'h0F};
    tbl[2] = '{2'd2, 8'b00000001, 8'h80};
    tbl[3] = '{2'd3, 8'b01010101, 8'hAA};
    model_step(1, 0, 0, 0, 0);
    cyc(1, 1, 2'($urandom), 4'($urandom), 1'($urandom));
    cyc(1, 1, 2'($urandom), 4'($urandom), 1'($urandom));
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_chan", 32'(out_chan), 0);
    chk("rst_ovf", 32'(overflow), 0);
    emit.delete();
    idle(6, 1);
    chk("rst_quiet", emit.size(), 0);
    for (int t = 0; t < 4; t++) begin
      do_reset();
      for (int i = 7; i >= 0; i--) cyc(0, 1, tbl[t].ch, lanes_with(tbl[t].ch, tbl[t].seq[i]), 1);
      chk("tbl_early", 32'(out_valid), 0);
      idle(1, 1);
      chk("tbl_valid", 32'(out_valid), 1);
      chk("tbl_data", 32'(out_data), 32'(tbl[t].exp));
      chk("tbl_chan", 32'(out_chan), 32'(tbl[t].ch));
      idle(1, 1);
      chk("tbl_once", 32'(out_valid), 0);
    end
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 1, lanes_with(1, 1), 1);
      cyc(0, 1, 2, lanes_with(2, 8'hA5 >> i), 1);
    end
    idle(4, 1);
    chk("il_count", emit.size(), 2);
    if (emit.size() == 2) begin
      chk("il_first", 32'(emit[0]), 32'({2'd1, 8'hFF}));
      chk("il_second", 32'(emit[1]), 32'({2'd2, 8'hA5}));
    end
    do_reset();
    for (int c = 0; c < 4; c++) send_word(2'(c), 8'(c + 1), 0);
    idle(1, 0);
    idle(5, 1);
    chk("arb_count", emit.size(), 4);
    for (int i = 0; i < 4 && i < emit.size(); i++) chk("arb_order", 32'(emit[i]), 32'({2'(i), 8'(i + 1)}));
    emit.delete();
    send_word(3, 8'h33, 0);
    send_word(3, 8'h44, 0);
    send_word(0, 8'h55, 0);
    idle(1, 0);
    idle(4, 1);
    chk("wrap_count", emit.size(), 3);
    if (emit.size() == 3) begin
      chk("wrap_0", 32'(emit[0]), 32'({2'd3, 8'h33}));
      chk("wrap_1", 32'(emit[1]), 32'({2'd0, 8'h55}));
      chk("wrap_2", 32'(emit[2]), 32'({2'd3, 8'h44}));
    end
    do_reset();
    send_word(3, 8'h11, 0);
    send_word(3, 8'h22, 0);
    send_word(3, 8'h33, 0);
    idle(1, 0);
    chk("ovf_flag", 32'(overflow), 32'(4'b1000));
    chk("ovf_hold", 32'(out_data), 32'h11);
    idle(3, 0);
    chk("ovf_stable", 32'(out_data), 32'h11);
    idle(4, 1);
    chk("ovf_count", emit.size(), 2);
    if (emit.size() == 2) begin
      chk("ovf_w0", 32'(emit[0]), 32'({2'd3, 8'h11}));
      chk("ovf_w1", 32'(emit[1]), 32'({2'd3, 8'h22}));
    end
    chk("ovf_sticky", 32'(overflow), 32'(4'b1000));
    do_reset();
    for (int i = 0; i < 5; i++) cyc(0, 1, 2, 4'($urandom), 1);
    cyc(1, 1, 2, 4'($urandom), 1);
    emit.delete();
    send_word(2, 8'h3C, 1);
    idle(4, 1);
    chk("mid_count", emit.size(), 1);
    if (emit.size() == 1) chk("mid_word", 32'(emit[0]), 32'({2'd2, 8'h3C}));
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic stall = (i / 300) % 2 == 1;
      cyc($urandom_range(0, 499) == 0, 1'($urandom), 2'($urandom), 4'($urandom),
          stall ? $urandom_range(0, 7) == 0 : $urandom_range(0, 3) != 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
